// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind the PE adder tree: aligns input-side tags to tree latency,
// reduces valid tree sums per group and queues finished group sums for write-back.
module psum_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_advance,
    input  logic                         tag_valid,
    input  logic                         tag_last,
    input  logic signed [DATA_WIDTH-1:0] sum_in,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         stall_req,
    output logic                         overflow_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic a_valid;
    logic a_last;

    generate
        if (LATENCY == 0) begin : g_direct
            assign a_valid = tag_valid;
            assign a_last  = tag_last;
        end else begin : g_shift
            logic [LATENCY-1:0] vsr;
            logic [LATENCY-1:0] lsr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vsr <= '0;
                    lsr <= '0;
                end else if (en_advance) begin
                    vsr[0] <= tag_valid;
                    lsr[0] <= tag_last;
                    for (int i = 1; i < LATENCY; i++) begin
                        vsr[i] <= vsr[i-1];
                        lsr[i] <= lsr[i-1];
                    end
                end
            end

            assign a_valid = vsr[LATENCY-1];
            assign a_last  = lsr[LATENCY-1];
        end
    endgenerate

    logic [0:0]                  state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic signed [ACC_WIDTH-1:0] nxt;
    logic                        beat;
    logic                        push;

    assign sum_ext = ACC_WIDTH'(sum_in);
    assign nxt     = ((state == ST_EMPTY) ? '0 : acc) + sum_ext;
    assign beat    = en_advance && a_valid;
    assign push    = beat && a_last;

    // The group state advances even when the FIFO drops the push, so the next group starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            state <= ST_EMPTY;
        end else if (beat) begin
            if (a_last) begin
                acc   <= '0;
                state <= ST_EMPTY;
            end else begin
                acc   <= nxt;
                state <= ST_ACCUM;
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]               wptr;
    logic [PW-1:0]               rptr;
    logic [PW-1:0]               rptr_n;
    logic [CW-1:0]               count;
    logic [CW-1:0]               count_n;
    logic                        full;
    logic                        pop;
    logic                        do_push;
    logic                        head_is_new;

    assign full        = (count == FULL_CNT);
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign do_push     = push && (!full || pop);
    assign stall_req   = full && !pop;
    assign rptr_n      = pop ? rptr + 1'b1 : rptr;
    assign count_n     = count + CW'(do_push) - CW'(pop);
    assign head_is_new = do_push && ((count - CW'(pop)) == '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= nxt;
        end
    end

    // out_data is a registered copy of the head; a push into an otherwise empty queue bypasses the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            out_data     <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            rptr  <= rptr_n;
            count <= count_n;
            if (push && full && !pop) begin
                overflow_err <= 1'b1;
            end
            if (count_n != '0) begin
                out_data <= head_is_new ? nxt : mem[rptr_n];
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a small tree-delay model feeds sums, and a
// scoreboard queue of hand-computed group sums is checked by a negedge monitor.
module tb_psum_accumulator;

    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int LAT = 3;
    localparam int FD  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en_advance;
    logic                 tag_valid;
    logic                 tag_last;
    logic signed [DW-1:0] sum_in;
    logic signed [AW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 stall_req;
    logic                 overflow_err;

    int                   vectors     = 0;
    int                   miscompares = 0;
    logic [AW-1:0]        expQ [$];
    logic [AW-1:0]        expv;
    logic signed [DW-1:0] pipe [LAT];

    localparam logic signed [DW-1:0] JUNK = 16'sh0BAD;

    always #5 clk = ~clk;

    psum_accumulator #(
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW),
        .LATENCY   (LAT),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_advance  (en_advance),
        .tag_valid   (tag_valid),
        .tag_last    (tag_last),
        .sum_in      (sum_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stall_req   (stall_req),
        .overflow_err(overflow_err)
    );

    task automatic checkOutput(input string name, input logic [AW-1:0] actual, input logic [AW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // The tree is modelled as a LAT-deep delay that only moves when en_advance is high.
    task automatic applyStimulus(input logic adv, input logic tv, input logic tl, input logic signed [DW-1:0] s);
        en_advance = adv;
        tag_valid  = tv;
        tag_last   = tl;
        sum_in     = pipe[LAT-1];
        @(posedge clk);
        #1;
        if (adv) begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = s;
        end
    endtask

    task automatic beat(input logic signed [DW-1:0] s, input logic last);
        applyStimulus(1'b1, 1'b1, last, s);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, JUNK);
    endtask

    initial begin
        rst        = 1'b1;
        en_advance = 1'b0;
        tag_valid  = 1'b0;
        tag_last   = 1'b0;
        sum_in     = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_output: got %h, expected none", out_data);
                    end else begin
                        expv = expQ.pop_front();
                        checkOutput("fifo_data", out_data, expv);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_stall_req", 32'(stall_req), 32'd0);
        checkOutput("reset_overflow", 32'(overflow_err), 32'd0);

        $display("[TB] four-beat group 10,-3,7,100");
        out_ready = 1'b1;
        beat(16'sd10, 1'b0);
        beat(-16'sd3, 1'b0);
        beat(16'sd7, 1'b0);
        expQ.push_back(32'd114);
        beat(16'sd100, 1'b1);
        idle(2);
        checkOutput("t1_not_yet_valid", 32'(out_valid), 32'd0);
        idle(1);
        checkOutput("t1_valid_rise", 32'(out_valid), 32'd1);
        idle(1);
        checkOutput("t1_popped", 32'(out_valid), 32'd0);

        $display("[TB] single-beat extremes");
        out_ready = 1'b0;
        expQ.push_back(32'hFFFF8000);
        beat(16'sh8000, 1'b1);
        expQ.push_back(32'h00007FFF);
        beat(16'sh7FFF, 1'b1);
        idle(3);
        checkOutput("t2_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        idle(3);

        $display("[TB] advance gaps and bubbles");
        expQ.push_back(32'd114);
        beat(16'sd10, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, JUNK);
        applyStimulus(1'b0, 1'b1, 1'b1, JUNK);
        applyStimulus(1'b0, 1'b1, 1'b1, JUNK);
        beat(-16'sd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, JUNK);
        beat(16'sd7, 1'b0);
        beat(16'sd100, 1'b1);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, JUNK);
        applyStimulus(1'b0, 1'b0, 1'b0, JUNK);
        idle(1);
        checkOutput("t3_tags_held", 32'(out_valid), 32'd0);
        idle(1);
        checkOutput("t3_valid", 32'(out_valid), 32'd1);
        idle(1);

        $display("[TB] fill, stall and simultaneous push/pop");
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            expQ.push_back(32'(v));
            beat(16'(v), 1'b1);
        end
        idle(2);
        checkOutput("t4_full_stall", 32'(stall_req), 32'd1);
        out_ready = 1'b1;
        #1;
        checkOutput("t4_pop_unstall", 32'(stall_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, JUNK);
        out_ready = 1'b0;
        #1;
        checkOutput("t4_count_still_full", 32'(stall_req), 32'd1);
        out_ready = 1'b1;
        idle(6);

        $display("[TB] overflow while full");
        out_ready = 1'b0;
        for (int v = 11; v <= 14; v++) begin
            expQ.push_back(32'(v));
            beat(16'(v), 1'b1);
        end
        beat(16'sd99, 1'b1);
        idle(3);
        checkOutput("t5_overflow_set", 32'(overflow_err), 32'd1);
        idle(2);
        checkOutput("t5_overflow_sticky", 32'(overflow_err), 32'd1);
        out_ready = 1'b1;
        idle(5);
        checkOutput("t5_drained", 32'(out_valid), 32'd0);
        expQ.push_back(32'd7);
        beat(16'sd7, 1'b1);
        idle(4);
        checkOutput("t5_overflow_still_set", 32'(overflow_err), 32'd1);

        $display("[TB] reset mid-group");
        beat(16'sd5, 1'b0);
        beat(16'sd6, 1'b0);
        idle(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t6_rst_clears_overflow", 32'(overflow_err), 32'd0);
        checkOutput("t6_rst_empty", 32'(out_valid), 32'd0);
        expQ.push_back(32'd9);
        beat(16'sd9, 1'b1);
        idle(4);

        for (int i = 0; i < 50 && expQ.size() != 0; i++) idle(1);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the pipelined PE adder tree.
- Tracks which tree outputs are valid by delaying an input-side tag through a shift register matched to the tree latency.
- Accumulates valid tree sums across a reduction group (e.g. input-channel tiles) into a wide accumulator.
- Pushes each completed group sum into a small output FIFO with a valid/ready interface to the write-back stage.

Parameters:
- DATA_WIDTH, 16: width of signed tree sum input.
- ACC_WIDTH, 32: accumulator and output width; must be >= DATA_WIDTH.
- LATENCY, 3: register stages of the upstream tree; equals $clog2(`HW_CONFIG_PE_NUM); 0 allowed.
- FIFO_DEPTH, 4: output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en_advance  in  1  pipeline advance; the same signal that drives the adder tree
- tag_valid  in  1  beat valid, presented with the tree's inputs
- tag_last  in  1  last beat of reduction group, presented with the tree's inputs; ignored unless tag_valid
- sum_in  in  DATA_WIDTH  signed tree output (adder_out)
- out_data  out  ACC_WIDTH  signed completed group sum (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accept
- stall_req  out  1  combinational; upstream must gate en_advance with !stall_req
- overflow_err  out  1  sticky; a push was attempted while the FIFO was full

Behaviour:
- Reset is synchronous with priority over everything:
  - Tag shift register cleared to {valid=0, last=0}.
  - acc=0; state=EMPTY.
  - FIFO pointers and count = 0; out_valid=0; out_data=0.
  - overflow_err=0.
- Tag alignment:
  - LATENCY-deep shift register of {tag_valid, tag_last}; shifts only when en_advance=1.
  - Aligned tag (a_valid, a_last) is the oldest entry, consumed in the same en_advance cycle in which the tree presents the corresponding sum_in.
  - LATENCY=0: the aligned tag is tag_valid/tag_last directly (combinational).
  - en_advance=0: shift register, acc and state all hold. The FIFO still pops normally.
- Arithmetic:
  - sum_ext = sign-extend(sum_in) to ACC_WIDTH.
  - nxt = (state==EMPTY ? 0 : acc) + sum_ext, two's-complement wrap modulo 2^ACC_WIDTH, no saturation.
- State machine (EMPTY, ACCUM), evaluated only when en_advance && a_valid:
  - a_last=0: acc<=nxt, state<=ACCUM.
  - a_last=1: push nxt into FIFO, acc<=0, state<=EMPTY.
  - Single-beat group (EMPTY with last) pushes sum_ext.
  - en_advance && !a_valid: no change. Bubbles inside a group are allowed and keep the partial sum.
- FIFO:
  - push = en_advance && a_valid && a_last; pop = out_valid && out_ready.
  - out_data is the registered head, valid in the same cycle out_valid=1.
  - First push into an empty FIFO is visible 1 cycle after the push edge.
  - Simultaneous push and pop when full: both occur, count unchanged.
  - Simultaneous push and pop when empty: no bypass; the push is stored, and the pop does not happen because out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- stall_req = (count==FIFO_DEPTH) && !pop. This is conservative and independent of a_last, so it never depends on en_advance (no combinational loop).
- Push while full and not popping (upstream violated stall_req):
  - Data is dropped; FIFO is unchanged.
  - overflow_err<=1 and stays set until rst.
  - acc/state still update as if the push succeeded.
- Reset mid-group discards the partial sum and all in-flight tags. The first aligned beat after reset starts from EMPTY.
- out_data holds its last value while out_valid=0 (after reset it is 0).

Test Plan:
- LATENCY=3, en_advance=1 continuously. Tags valid for 4 beats, last on beat 4, tree sums 10,-3,7,100 → exactly one push of 114; out_valid rises 1 cycle after the beat-4 aligned cycle; out_ready=1 pops it the next cycle.
- Single-beat groups back-to-back, sums -32768 then 32767, DATA_WIDTH=16 → FIFO holds 0xFFFF8000 then 0x00007FFF as sign-extended 32-bit values, in order.
- en_advance toggled 1,0,0,1 mid-group, bubble tags (valid=0) inside the group → sum is unchanged versus the continuous run, and the tag shift register holds during en_advance=0.
- out_ready=0, push 4 groups → count=4 and stall_req=1; then out_ready=1 with a simultaneous fifth push → stall_req=0 that cycle, count stays 4, and values drain in order 1..5.
- Force a push while full with out_ready=0 → overflow_err=1 and stays set, FIFO contents unchanged; rst clears it.
- Assert rst for 1 cycle after 2 beats of a group (sums 5,6), then a new group of 1 (last, sum 9) → output 9, not 20.
